// File: rtl/muldiv_sequencer.sv
// Iterative unsigned shift-add multiplier / restoring divider, one iteration per clock.
// Optional MULDIV_HI_EN builds the high-product / remainder output register; otherwise hi is 0.
`timescale 1ns/1ps
module muldiv_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             ovf,
  output logic             dz
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               op_r;
  logic [WIDTH-1:0]   opnd;       // multiplicand (MUL) or divisor (DIV)
  logic [2*WIDTH-1:0] acc;        // {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_nxt;

  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One iteration of each algorithm; op_r picks which one lands in acc.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    q_bit    = (rem_sh >= {1'b0, opnd});
    rem_nxt  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    if (op_r) begin
      acc_nxt = {rem_nxt, acc[WIDTH-2:0], q_bit};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_r   <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_r <= op;
      opnd <= op ? b_in : a_in;
      acc  <= {{WIDTH{1'b0}}, (op ? a_in : b_in)};
    end else if (state == S_RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        result <= acc_nxt[WIDTH-1:0];
        ovf    <= !op_r && (acc_nxt[2*WIDTH-1:WIDTH] != '0);
        dz     <= op_r && (opnd == '0);
      end
    end
  end

`ifdef MULDIV_HI_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
    end else if (state == S_RUN && last_iter && !accept) begin
      hi <= acc_nxt[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign hi = '0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: MUL/DIV vectors, latency, ignore-in-RUN, back-to-back, async reset.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             ovf;
  logic             dz;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .ovf    (ovf),
    .dz     (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called 1ns after an edge; the next edge samples start. Operands are scrambled afterwards.
  task automatic start_op(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input string tag);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clk); #1;
    start = 1'b0;
    op    = ~o;
    a_in  = 8'hA5;
    b_in  = 8'h3C;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_done_after_start"}, done, 0);
  endtask

  // elapsed = edges already consumed since the accepting edge.
  task automatic finish_op(input int elapsed, input logic [WIDTH-1:0] exp_res,
                           input logic [WIDTH-1:0] exp_hi, input logic exp_ovf,
                           input logic exp_dz, input string tag);
    repeat (WIDTH - 1 - elapsed) @(posedge clk);
    #1;
    chk({tag, "_busy_last_iter"}, busy, 1);
    chk({tag, "_done_last_iter"}, done, 0);
    @(posedge clk); #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_result"}, result, exp_res);
`ifdef MULDIV_HI_EN
    chk({tag, "_hi"}, hi, exp_hi);
`else
    chk({tag, "_hi"}, hi, 0);
    if (exp_hi == 8'hFF) $display("unused hi reference");
`endif
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_dz"}, dz, exp_dz);
  endtask

  initial begin
    int done_seen;
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", dz, 0);
    rst = 1'b0;

    // MUL 7*6 = 42
    start_op(1'b0, 8'd7, 8'd6, "mul7x6");
    finish_op(0, 8'd42, 8'd0, 1'b0, 1'b0, "mul7x6");
    @(posedge clk); #1;
    chk("mul7x6_done_one_cycle", done, 0);
    chk("mul7x6_result_held", result, 42);

    // DIV 200/7 = 28 r 4
    start_op(1'b1, 8'd200, 8'd7, "div200by7");
    chk("div200by7_result_held_in_run", result, 42);
    finish_op(0, 8'd28, 8'd4, 1'b0, 1'b0, "div200by7");
    @(posedge clk); #1;

    // MUL 17*16 = 0x110
    start_op(1'b0, 8'd17, 8'd16, "mul17x16");
    finish_op(0, 8'h10, 8'h01, 1'b1, 1'b0, "mul17x16");
    @(posedge clk); #1;

    // DIV 9/0 -> quotient all ones, remainder = dividend
    start_op(1'b1, 8'd9, 8'd0, "div9by0");
    finish_op(0, 8'hFF, 8'd9, 1'b0, 1'b1, "div9by0");
    @(posedge clk); #1;

    // DIV 100/9 = 11 r 1, with a start pulse mid-RUN that must be ignored
    start_op(1'b1, 8'd100, 8'd9, "div100by9");
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 1'b0;
    a_in  = 8'd3;
    b_in  = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("div100by9_busy_after_ignored_start", busy, 1);
    finish_op(3, 8'd11, 8'd1, 1'b0, 1'b0, "div100by9");

    // Back-to-back: start during the DONE cycle, MUL 3*5 = 15
    start_op(1'b0, 8'd3, 8'd5, "mul3x5_b2b");
    chk("mul3x5_b2b_result_held", result, 11);
    finish_op(0, 8'd15, 8'd0, 1'b0, 1'b0, "mul3x5_b2b");
    @(posedge clk); #1;

    // Async reset pulse mid-RUN, between edges
    start_op(1'b0, 8'd17, 8'd16, "rst_mid");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_result", result, 0);
    chk("rstmid_hi", hi, 0);
    chk("rstmid_ovf", ovf, 0);
    chk("rstmid_dz", dz, 0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("rstmid_no_done_after_reset", done_seen, 0);

    // Post-reset operation behaves as from power-up
    start_op(1'b0, 8'd7, 8'd6, "post_rst_mul");
    finish_op(0, 8'd42, 8'd0, 1'b0, 1'b0, "post_rst_mul");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide engine and sequencer for the SAP-1 accumulator datapath.
- The controller raises `start` with an opcode select when it reaches the MUL or DIV execute stage. It then stalls on `busy` and loads `result` into A when `done` pulses.
- Multiply is iterative shift-add; divide is restoring division. Both take one iteration per clock, so no combinational multiplier or divider sits on the W-bus.

Parameters:
- WIDTH, 8, operand and result width in bits (A and B register width).
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a new operation; sampled only when accepting (IDLE or DONE).
- op  input  1  0 = MUL, 1 = DIV; sampled with start.
- a_in  input  WIDTH  multiplicand / dividend (A register); sampled with start.
- b_in  input  WIDTH  multiplier / divisor (B register); sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  low WIDTH bits of product, or quotient.
- hi  output  WIDTH  high product bits / remainder (see Optional Feature).
- ovf  output  1  MUL: product high half nonzero; DIV: 0.
- dz  output  1  DIV with b_in == 0; MUL: 0.

Behaviour:
- Reset: asynchronous and active-high; overrides everything, including mid-operation.
  - State returns to IDLE immediately.
  - busy, done, result, hi, ovf and dz all go to 0; the counter and internal registers clear.
  - The in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch op, a_in, b_in; clear the partial accumulator; counter = 0; go to RUN.
  - Otherwise remain in IDLE.
- RUN:
  - busy = 1.
  - Each edge performs one iteration and increments the counter.
  - After iteration WIDTH (counter == WIDTH-1 at that edge): register result, hi, ovf and dz; go to DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle.
  - Next edge: if start=1, accept the new operation exactly as from IDLE (back-to-back); else go to IDLE.
- Latency: start sampled at edge k → busy high from after edge k; done high during the cycle after edge k+WIDTH. Total WIDTH+1 cycles from request to result.
- start while in RUN is ignored; there is no queueing. Operand inputs may change freely once start has been sampled.
- result, hi, ovf and dz hold their values from DONE until the next accepted start completes. They do not change during RUN.
- MUL: 2*WIDTH-bit shift-add, LSB-first on the multiplier.
  - result = product[WIDTH-1:0].
  - ovf = (product[2*WIDTH-1:WIDTH] != 0).
- DIV: unsigned restoring division.
  - result = quotient; remainder is kept internally.
  - b_in == 0 runs the full WIDTH iterations with no special path. The result is quotient = all ones, remainder = dividend, and dz = 1.
- All arithmetic is unsigned. There is no sign handling.

Optional Feature:
- Macro: MULDIV_HI_EN.
- Defined:
  - hi = product[2*WIDTH-1:WIDTH] for MUL, remainder for DIV.
  - hi is registered with result.
- Undefined:
  - hi is tied to 0 and the high-half/remainder output register is not built.
  - ovf and dz are unaffected, since the internal accumulator still exists.

Test Plan:
- Reset, then MUL 7*6 (start for one cycle) → busy for 8 cycles; done pulse on cycle 9 with result=42, ovf=0, dz=0; hi=0 with the macro.
- DIV 200/7 → done after 9 cycles; result=28, dz=0; hi=4 with the macro, 0 without.
- MUL 17*16 → result=0x10, ovf=1; hi=0x01 with the macro.
- DIV 9/0 → full 9-cycle latency; result=0xFF, dz=1; hi=9 with the macro.
- Pulse start again mid-RUN with different operands → ignored; the original result arrives on schedule. Then assert start during the DONE cycle (MUL 3*5) → accepted; result=15 after a further WIDTH+1 cycles.
- Assert rst for 1 ns mid-RUN, between clock edges → busy, done, result, hi, ovf and dz drop to 0 immediately. No done pulse follows, and the next start behaves as if from power-up.
